syncword_correlator: RTL and testbench

Receive-side access-code correlator, directly upstream of the header bit processor. Shifts in the demodulated rxbit stream once per p_1us strobe and compares the last 64 bits against the programmed sync word, with a programmable Hamming-distance tolerance. On a match it emits rx_trailer_st_p, which starts the header/HEC receive sequence. Gives up after a programmable search window.

---
 rtl/syncword_correlator.sv | 124 ++++++++++++
 tb/tb_syncword_correlator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/syncword_correlator.sv
// Access-code correlator: shifts the demodulated bit stream in once per
// microsecond tick, compares the last SW_LEN bits against the programmed
// sync word with a Hamming-distance tolerance, and on a hit kicks off the
// header receive sequence. An optional search window bounds the hunt.
module syncword_correlator #(
    parameter int SW_LEN = 64,
    parameter int WIN_W  = 16
) (
    input  logic              clk_6M,
    input  logic              rst,
    input  logic              p_1us,
    input  logic              rxbit,
    input  logic              corr_en,
    input  logic [SW_LEN-1:0] regi_syncword,
    input  logic [5:0]        regi_corr_thresh,
    input  logic [WIN_W-1:0]  regi_search_window,
    output logic              rx_trailer_st_p,
    output logic              sync_found,
    output logic              sync_timeout,
    output logic [6:0]        corr_errcnt
);

    localparam int FILL_W = $clog2(SW_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        FOUND,
        LOCKED,
        IDLE_WAIT
    } state_t;

    state_t              state;
    logic [SW_LEN-1:0]   sr;
    logic [FILL_W-1:0]   fill_cnt;
    logic [WIN_W-1:0]    win_cnt;
    logic                cmp_pend;   // a bit was shifted last cycle, compare now
    logic [6:0]          errs;
    logic                sr_full;
    logic                hit;
    logic                win_expired;

    // Hamming distance between the received window and the sync word
    always_comb begin
        errs = '0;
        for (int i = 0; i < SW_LEN; i++)
            errs = errs + {6'd0, sr[i] ^ regi_syncword[i]};
    end

    assign sr_full     = (fill_cnt == FILL_W'(SW_LEN));
    assign hit         = sr_full && (errs <= {1'b0, regi_corr_thresh});
    assign win_expired = (regi_search_window != '0) && (win_cnt == regi_search_window);

    // Search FSM: shift on the strobe, decide on the following cycle so the
    // compare always sees the updated window. Strobes are assumed to be at
    // least two clk_6M cycles apart (they are 6 apart at 1 us).
    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state           <= IDLE;
            sr              <= '0;
            fill_cnt        <= '0;
            win_cnt         <= '0;
            cmp_pend        <= 1'b0;
            rx_trailer_st_p <= 1'b0;
            sync_found      <= 1'b0;
            sync_timeout    <= 1'b0;
            corr_errcnt     <= '0;
        end else if (!corr_en) begin
            // Abort from anywhere; the last accepted error count is kept
            state           <= IDLE;
            sr              <= '0;
            fill_cnt        <= '0;
            win_cnt         <= '0;
            cmp_pend        <= 1'b0;
            rx_trailer_st_p <= 1'b0;
            sync_found      <= 1'b0;
            sync_timeout    <= 1'b0;
        end else begin
            sync_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    sr       <= '0;
                    fill_cnt <= '0;
                    win_cnt  <= '0;
                    cmp_pend <= 1'b0;
                    state    <= SEARCH;
                end
                SEARCH: begin
                    if (cmp_pend) begin
                        cmp_pend <= 1'b0;
                        // A hit on the final window bit beats window expiry
                        if (hit) begin
                            corr_errcnt     <= errs;
                            sync_found      <= 1'b1;
                            rx_trailer_st_p <= 1'b1;
                            state           <= FOUND;
                        end else if (win_expired) begin
                            sync_timeout <= 1'b1;
                            state        <= IDLE_WAIT;
                        end
                    end else if (p_1us) begin
                        sr       <= {sr[SW_LEN-2:0], rxbit};
                        win_cnt  <= win_cnt + WIN_W'(1);
                        cmp_pend <= 1'b1;
                        if (!sr_full)
                            fill_cnt <= fill_cnt + FILL_W'(1);
                    end
                end
                FOUND: begin
                    // Hold the request across one strobe so the header
                    // processor samples it exactly once
                    if (p_1us) begin
                        rx_trailer_st_p <= 1'b0;
                        state           <= LOCKED;
                    end
                end
                LOCKED:    state <= LOCKED;
                IDLE_WAIT: state <= IDLE_WAIT;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syncword_correlator.sv
// Randomized bench for syncword_correlator with a queue-based reference
// model and a per-cycle output compare, plus directed scenarios.
module tb_syncword_correlator;

    logic        clk_6M = 1'b0;
    logic        rst = 1'b1;
    logic        p_1us = 1'b0;
    logic        rxbit = 1'b0;
    logic        corr_en = 1'b0;
    logic [63:0] regi_syncword = '0;
    logic [5:0]  regi_corr_thresh = '0;
    logic [15:0] regi_search_window = '0;
    logic        rx_trailer_st_p;
    logic        sync_found;
    logic        sync_timeout;
    logic [6:0]  corr_errcnt;

    syncword_correlator #(.SW_LEN(64), .WIN_W(16)) dut (
        .clk_6M             (clk_6M),
        .rst                (rst),
        .p_1us              (p_1us),
        .rxbit              (rxbit),
        .corr_en            (corr_en),
        .regi_syncword      (regi_syncword),
        .regi_corr_thresh   (regi_corr_thresh),
        .regi_search_window (regi_search_window),
        .rx_trailer_st_p    (rx_trailer_st_p),
        .sync_found         (sync_found),
        .sync_timeout       (sync_timeout),
        .corr_errcnt        (corr_errcnt)
    );

    always #5 clk_6M = ~clk_6M;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_strobe = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    // Keeps the bits heard since the hunt began; at each strobe it decides
    // from the last 64 bits whether this bit completes a match or exhausts
    // the window, and the outcome shows up on the outputs one cycle later.
    bit         bq[$];
    bit         active = 0, hunting = 0;
    int         ntick = 0;
    int         due = 0;        // 0 none, 1 match, 2 timeout
    int         due_errs = 0;
    logic       e_trail = 0, e_found = 0, e_to = 0;
    logic [6:0] e_err = 0;

    always @(posedge clk_6M) begin
        cyc++;
        if (p_1us) last_strobe = cyc;
        if (rst) begin
            bq.delete(); active = 0; hunting = 0; due = 0; ntick = 0;
            e_trail = 0; e_found = 0; e_to = 0; e_err = 0;
        end else if (!corr_en) begin
            bq.delete(); active = 0; hunting = 0; due = 0; ntick = 0;
            e_trail = 0; e_found = 0; e_to = 0;
        end else if (!active) begin
            active = 1; hunting = 1; ntick = 0; due = 0; bq.delete(); e_to = 0;
        end else begin
            e_to = 0;
            if (due == 1) begin
                e_trail = 1; e_found = 1; e_err = 7'(due_errs); hunting = 0; due = 0;
            end else if (due == 2) begin
                e_to = 1; hunting = 0; due = 0;
            end else if (hunting && p_1us) begin
                int errs;
                bq.push_back(rxbit);
                if (bq.size() > 64) void'(bq.pop_front());
                ntick++;
                if (bq.size() == 64) begin
                    errs = 0;
                    for (int i = 0; i < 64; i++)
                        if (bq[i] != regi_syncword[63-i]) errs++;
                    if (errs <= int'(regi_corr_thresh)) begin
                        due = 1; due_errs = errs;
                    end
                end
                if (due == 0 && regi_search_window != 0 && ntick == int'(regi_search_window))
                    due = 2;
            end else if (e_trail && p_1us) begin
                e_trail = 0;
            end
        end
    end

    // ---------------- compare + event monitor ----------------
    int  n_rise = 0, n_samp = 0, n_to = 0;
    int  rise_lat = -1, to_lat = -1;
    bit  prev_tr = 0;

    always @(negedge clk_6M) begin
        if (chk_en) begin
            chk("rx_trailer_st_p", {6'd0, rx_trailer_st_p}, {6'd0, e_trail});
            chk("sync_found",      {6'd0, sync_found},      {6'd0, e_found});
            chk("sync_timeout",    {6'd0, sync_timeout},    {6'd0, e_to});
            chk("corr_errcnt",     corr_errcnt,             e_err);
        end
        if (rx_trailer_st_p === 1'b1 && !prev_tr) begin
            n_rise++; rise_lat = cyc - last_strobe;
        end
        if (rx_trailer_st_p === 1'b1 && p_1us) n_samp++;
        if (sync_timeout === 1'b1) begin
            n_to++; to_lat = cyc - last_strobe;
        end
        prev_tr = (rx_trailer_st_p === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) begin @(posedge clk_6M); #2; end
    endtask

    task automatic tick(input logic b);
        @(posedge clk_6M); #2; p_1us = 1'b1; rxbit = b;
        @(posedge clk_6M); #2; p_1us = 1'b0; rxbit = 1'($urandom_range(0, 1));
        wait_cyc(4);
    endtask

    task automatic send_word(input logic [63:0] w, input int nbits);
        for (int i = 63; i > 63 - nbits; i--) tick(w[i]);
    endtask

    task automatic rand_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'($urandom_range(0, 1)));
    endtask

    function automatic logic [63:0] flip(input logic [63:0] w, input int n);
        logic [63:0] r;
        r = w;
        for (int i = 0; i < n; i++) r[$urandom_range(0, 63)] ^= 1'b1;
        return r;
    endfunction

    task automatic restart(input logic [63:0] sw, input logic [5:0] th, input logic [15:0] win);
        corr_en = 1'b0; wait_cyc(2);
        regi_syncword = sw; regi_corr_thresh = th; regi_search_window = win;
        corr_en = 1'b1; wait_cyc(2);
    endtask

    localparam logic [63:0] SW = 64'hA5F0_3C96_0F1E_7788;

    initial begin
        logic [63:0] w;
        int b_rise, b_samp, b_to;

        // reset
        rst = 1'b1; wait_cyc(3);
        chk_en = 1'b1;
        chk("reset_trailer", {6'd0, rx_trailer_st_p}, 7'd0);
        chk("reset_found",   {6'd0, sync_found},      7'd0);
        chk("reset_timeout", {6'd0, sync_timeout},    7'd0);
        chk("reset_errcnt",  corr_errcnt,             7'd0);
        rst = 1'b0; wait_cyc(2);

        // exact match with latency and single-sample hold
        restart(SW, 6'd0, 16'd0);
        b_rise = n_rise; b_samp = n_samp;
        rand_ticks(100);
        send_word(SW, 64);
        chk("exact_rise_latency", 7'(rise_lat), 7'd1);
        chk("exact_trailer_held", {6'd0, rx_trailer_st_p}, 7'd1);
        tick(1'b0);
        chk("exact_one_rise", 7'(n_rise - b_rise), 7'd1);
        chk("exact_one_sample", 7'(n_samp - b_samp), 7'd1);
        chk("exact_trailer_cleared", {6'd0, rx_trailer_st_p}, 7'd0);
        chk("exact_found", {6'd0, sync_found}, 7'd1);
        chk("exact_errcnt", corr_errcnt, 7'd0);

        // tolerance accepted
        restart(SW, 6'd4, 16'd0);
        w = SW; w[5] = ~w[5]; w[20] = ~w[20]; w[60] = ~w[60];
        rand_ticks(100);
        send_word(w, 64);
        chk("tol_found", {6'd0, sync_found}, 7'd1);
        chk("tol_errcnt", corr_errcnt, 7'd3);
        chk("tol_model_err", e_err, 7'd3);

        // synchronous reset mid-operation
        rst = 1'b1; wait_cyc(1);
        chk("rst_errcnt", corr_errcnt, 7'd0);
        chk("rst_found", {6'd0, sync_found}, 7'd0);
        rst = 1'b0; wait_cyc(1);

        // tolerance rejected, window expiry
        restart(SW, 6'd4, 16'd200);
        b_rise = n_rise; b_to = n_to;
        w = SW; w[0] = ~w[0]; w[13] = ~w[13]; w[27] = ~w[27]; w[41] = ~w[41]; w[63] = ~w[63];
        rand_ticks(100);
        send_word(w, 64);
        chk("win_no_early_to", 7'(n_to - b_to), 7'd0);
        rand_ticks(36);
        chk("win_one_timeout", 7'(n_to - b_to), 7'd1);
        chk("win_to_latency", 7'(to_lat), 7'd1);
        send_word(SW, 64);
        tick(1'b1);
        chk("win_no_rise", 7'(n_rise - b_rise), 7'd0);
        chk("win_stays_waiting", 7'(n_to - b_to), 7'd1);
        chk("win_not_found", {6'd0, sync_found}, 7'd0);

        // fill guard with a fully permissive threshold
        restart(SW, 6'd63, 16'd0);
        rand_ticks(10);
        chk("fill_10_bits", {6'd0, sync_found}, 7'd0);
        rand_ticks(53);
        chk("fill_63_bits", {6'd0, sync_found}, 7'd0);
        rand_ticks(1);
        chk("fill_64_bits", {6'd0, sync_found}, 7'd1);

        // abort after 40 sync bits, then a clean word
        restart(SW, 6'd0, 16'd0);
        b_rise = n_rise;
        send_word(SW, 40);
        corr_en = 1'b0; wait_cyc(3);
        corr_en = 1'b1; wait_cyc(2);
        send_word(SW, 64);
        tick(1'b0);
        chk("abort_single_rise", 7'(n_rise - b_rise), 7'd1);
        chk("abort_errcnt", corr_errcnt, 7'd0);

        // match and window expiry on the same bit
        restart(SW, 6'd0, 16'd64);
        b_rise = n_rise; b_to = n_to;
        send_word(SW, 64);
        tick(1'b0);
        chk("tie_found", {6'd0, sync_found}, 7'd1);
        chk("tie_rise", 7'(n_rise - b_rise), 7'd1);
        chk("tie_no_timeout", 7'(n_to - b_to), 7'd0);

        // randomized soak against the model
        for (int ep = 0; ep < 6; ep++) begin
            restart({$urandom, $urandom}, 6'($urandom_range(0, 6)),
                    ($urandom_range(0, 1) == 1) ? 16'd0 : 16'($urandom_range(64, 180)));
            for (int k = 0; k < 120; k++) begin
                case ($urandom_range(0, 19))
                    0: send_word(flip(regi_syncword, $urandom_range(0, 7)), 64);
                    1: begin corr_en = 1'b0; wait_cyc($urandom_range(1, 3)); corr_en = 1'b1; wait_cyc(1); end
                    default: tick(1'($urandom_range(0, 1)));
                endcase
            end
        end

        corr_en = 1'b0; wait_cyc(3);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
